// File: rtl/imem_loader.sv
// Instruction-memory write-side loader: takes 32-bit words from a valid/ready link and
// writes them as four little-endian bytes, filling IMEM upward from byte address 0.
module imem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  word_valid_i,
  input  logic [31:0]           word_data_i,
  input  logic                  word_last_i,
  output logic                  word_ready_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [7:0]            mem_wdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o,
  output logic [ADDR_WIDTH-2:0] word_count_o
);

  localparam int SLOT_W = ADDR_WIDTH - 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RECV  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  localparam logic [SLOT_W-1:0]     SLOT_ONE  = {{(SLOT_W-1){1'b0}}, 1'b1};
  localparam logic [SLOT_W-1:0]     SLOT_LAST = {SLOT_W{1'b1}};
  localparam logic [ADDR_WIDTH-2:0] CNT_ONE   = {{(ADDR_WIDTH-2){1'b0}}, 1'b1};

  logic [2:0]            state_q, state_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [1:0]            byte_q, byte_d;
  logic [31:0]           word_q, word_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-2:0] count_q, count_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]            mem_wdata_q, mem_wdata_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic                  accept_s;

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] k);
    case (k)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  assign accept_s = word_valid_i & ready_q;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    byte_d      = byte_q;
    word_d      = word_q;
    last_d      = last_q;
    count_d     = count_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i) begin
          state_d = ST_RECV;
          slot_d  = '0;
          byte_d  = 2'd0;
          count_d = '0;
        end else begin
          state_d = state_q;
        end
      end
      ST_RECV: begin
        // A start pulse here is ignored, so a coincident handshake always wins.
        if (accept_s) begin
          word_d  = word_data_i;
          last_d  = word_last_i;
          byte_d  = 2'd0;
          state_d = ST_WRITE;
        end else begin
          state_d = ST_RECV;
        end
      end
      ST_WRITE: begin
        if (byte_q == 2'd3) begin
          count_d = count_q + CNT_ONE;
          slot_d  = slot_q + SLOT_ONE;
          byte_d  = 2'd0;
          if (last_q) begin
            state_d = ST_DONE;
          end else if (slot_q == SLOT_LAST) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_RECV;
          end
        end else begin
          byte_d = byte_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Write strobe is aligned with the WRITE state; the address is held between writes.
    mem_we_d = (state_d == ST_WRITE);
    if (mem_we_d) begin
      mem_addr_d  = {slot_d, byte_d};
      mem_wdata_d = pick_byte(word_d, byte_d);
    end else begin
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
    end

    ready_d = (state_d == ST_RECV);
    busy_d  = (state_d == ST_RECV) || (state_d == ST_WRITE);
    done_d  = (state_d == ST_DONE);
    ovf_d   = (state_d == ST_ERR);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      slot_q      <= '0;
      byte_q      <= 2'd0;
      word_q      <= 32'd0;
      last_q      <= 1'b0;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      byte_q      <= byte_d;
      word_q      <= word_d;
      last_q      <= last_d;
      count_q     <= count_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  assign word_ready_o = ready_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign overflow_o   = ovf_q;
  assign word_count_o = count_q;

endmodule
